bw_r_rf_2r1w_param: RTL and testbench

Parametrised register-file macro model: DEPTH x WIDTH array with one write port and two independent read ports. WIDTH bits are split into LANES lanes by interleave, with a per-lane write enable.
Input pipeline flops with sehold. Write and read both occur one cycle after input capture, and read data is registered.
Configurable same-address read/write behaviour: bypass (forward new data) or old-data. Used as the successor macro for queue/buffer arrays that need two readers (e.g. issue and retire pointers).

---
 rtl/bw_rf_pkg.sv | 40 ++++
 rtl/bw_r_rf_lane_mask.sv | 31 +++
 rtl/bw_r_rf_2r1w_param.sv | 137 +++++++++++++
 tb/tb_bw_r_rf_2r1w_param.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bw_rf_pkg.sv
// Shared helpers for the bw_r_rf register-file family.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
//
// Lanes are bit-interleaved: bit i of a word belongs to lane i % LANES.
package bw_rf_pkg;

  // Upper bounds for the generic mask-expansion helper.
  localparam int MAX_WIDTH = 1024;
  localparam int MAX_LANES = 64;

  // Same-address read behaviour while a write to that address is in flight.
  typedef enum logic {
    RD_OLD_DATA = 1'b0,
    RD_BYPASS   = 1'b1
  } rd_mode_e;

  // Lane that owns bit position bit_idx.
  function automatic int lane_of(input int bit_idx, input int lanes);
    return bit_idx % lanes;
  endfunction

  // Expand a per-lane enable vector into a per-bit mask. Bits at or above
  // 'width' are returned as zero.
  function automatic logic [MAX_WIDTH-1:0] expand_lane_mask(
    input logic [MAX_LANES-1:0] lane_mask,
    input int                   width,
    input int                   lanes
  );
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) begin
        m[i] = lane_mask[6'(lane_of(i, lanes))];
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/bw_r_rf_lane_mask.sv
// Effective per-bit write mask for the register file (lane enable gated by
// the write enable and the live test write gate).
// Latency: combinational. Backpressure: none.
//
// Ports:
//   word_wen_d1  registered lane enables
//   wr_en_d1     registered write enable
//   rst_tri_en   live write gate, 1 blocks every lane
//   wmask        WIDTH-bit mask, bit i follows lane i % LANES
module bw_r_rf_lane_mask
  import bw_rf_pkg::*;
#(
  parameter int WIDTH = 108,
  parameter int LANES = 4
) (
  input  logic [LANES-1:0] word_wen_d1,
  input  logic             wr_en_d1,
  input  logic             rst_tri_en,
  output logic [WIDTH-1:0] wmask
);

  logic [LANES-1:0] lane_en;

  assign lane_en = word_wen_d1 & {LANES{wr_en_d1 & ~rst_tri_en}};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    localparam int L = lane_of(i, LANES);
    assign wmask[i] = lane_en[L];
  end

endmodule

// File: rtl/bw_r_rf_2r1w_param.sv
// DEPTH x WIDTH register file, one lane-masked write port, two read ports.
// Latency: inputs captured at edge N; write and registered read at N+1.
// Backpressure: none; sehold freezes the input stage (held ops repeat).
//
// Ports:
//   rclk, reset_l          clock, synchronous active-low reset
//   din, wr_adr, wr_en     write data / address / enable
//   word_wen               lane enables (bit i of din is in lane i % LANES)
//   rd_adr0/1, read_en0/1  read addresses / enables
//   rst_tri_en             live write gate (scan/test)
//   sehold                 hold all input-stage flops
//   dout0, dout1           registered read data
module bw_r_rf_2r1w_param
  import bw_rf_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int WIDTH  = 108,
  parameter int LANES  = 4,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic             rclk,
  input  logic             reset_l,
  input  logic [WIDTH-1:0] din,
  input  logic [AW-1:0]    wr_adr,
  input  logic             wr_en,
  input  logic [LANES-1:0] word_wen,
  input  logic [AW-1:0]    rd_adr0,
  input  logic             read_en0,
  input  logic [AW-1:0]    rd_adr1,
  input  logic             read_en1,
  input  logic             rst_tri_en,
  input  logic             sehold,
  output logic [WIDTH-1:0] dout0,
  output logic [WIDTH-1:0] dout1
);

  localparam rd_mode_e RD_MODE = (BYPASS != 0) ? RD_BYPASS : RD_OLD_DATA;
  // Address compare is done one bit wider so DEPTH == 2**AW still works.
  localparam logic [AW:0] DEPTH_EXT = (AW+1)'(DEPTH);

  // ---------------- stage 1: input capture ----------------
  logic [WIDTH-1:0] din_d1;
  logic [AW-1:0]    wr_adr_d1;
  logic             wr_en_d1;
  logic [LANES-1:0] word_wen_d1;
  logic [AW-1:0]    rd_adr_d1  [2];
  logic             read_en_d1 [2];

  logic [AW-1:0]    rd_adr_in  [2];
  logic             read_en_in [2];

  assign rd_adr_in[0]  = rd_adr0;
  assign rd_adr_in[1]  = rd_adr1;
  assign read_en_in[0] = read_en0;
  assign read_en_in[1] = read_en1;

  // Reset overrides sehold so the enables always come out of reset idle.
  always_ff @(posedge rclk) begin
    if (!reset_l) begin
      din_d1      <= '0;
      wr_adr_d1   <= '0;
      wr_en_d1    <= 1'b0;
      word_wen_d1 <= '0;
      for (int k = 0; k < 2; k++) begin
        rd_adr_d1[k]  <= '0;
        read_en_d1[k] <= 1'b0;
      end
    end else if (!sehold) begin
      din_d1      <= din;
      wr_adr_d1   <= wr_adr;
      wr_en_d1    <= wr_en;
      word_wen_d1 <= word_wen;
      for (int k = 0; k < 2; k++) begin
        rd_adr_d1[k]  <= rd_adr_in[k];
        read_en_d1[k] <= read_en_in[k];
      end
    end
  end

  // ---------------- stage 2: array write ----------------
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] wmask;
  logic             wr_in_range;

  bw_r_rf_lane_mask #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_lane_mask (
    .word_wen_d1 (word_wen_d1),
    .wr_en_d1    (wr_en_d1),
    .rst_tri_en  (rst_tri_en),
    .wmask       (wmask)
  );

  assign wr_in_range = {1'b0, wr_adr_d1} < DEPTH_EXT;

  // No array update on a reset edge; contents survive reset.
  always_ff @(posedge rclk) begin
    if (reset_l && wr_in_range && (|wmask)) begin
      mem[wr_adr_d1] <= (mem[wr_adr_d1] & ~wmask) | (din_d1 & wmask);
    end
  end

  // ---------------- stage 2: read ports ----------------
  for (genvar k = 0; k < 2; k++) begin : g_rd
    logic             rd_in_range;
    logic             hit;
    logic [WIDTH-1:0] stored;
    logic [WIDTH-1:0] rd_next;
    logic [WIDTH-1:0] dout_r;

    assign rd_in_range = {1'b0, rd_adr_d1[k]} < DEPTH_EXT;
    // 'stored' is the pre-write view of the array on this edge.
    assign stored      = rd_in_range ? mem[rd_adr_d1[k]] : '0;
    // An in-range read matching the write address implies an in-range write.
    assign hit         = rd_in_range && (rd_adr_d1[k] == wr_adr_d1) && (|wmask);

    if (RD_MODE == RD_BYPASS) begin : g_byp
      assign rd_next = hit ? ((stored & ~wmask) | (din_d1 & wmask)) : stored;
    end else begin : g_old
      assign rd_next = stored;
    end

    always_ff @(posedge rclk) begin
      if (!reset_l) begin
        dout_r <= '0;
      end else if (read_en_d1[k]) begin
        dout_r <= rd_next;
      end
    end
  end

  assign dout0 = g_rd[0].dout_r;
  assign dout1 = g_rd[1].dout_r;

endmodule

// File: tb/tb_bw_r_rf_2r1w_param.sv
// Bench for bw_r_rf_2r1w_param: three instances sharing one stimulus stream
// (DEPTH=32 bypass, DEPTH=32 old-data, DEPTH=20 bypass). Expected read data
// is queued with the cycle it is due; a negedge monitor compares it.
module tb_bw_r_rf_2r1w_param;

  localparam int W  = 108;
  localparam int AW = 5;

  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] ZERO = '0;
  localparam logic [W-1:0] P2   = {27{4'h4}};           // lane 2 only
  localparam logic [W-1:0] P3   = {27{4'h3}};           // lanes 0 and 1
  localparam logic [W-1:0] D4   = {27{4'h6}};
  localparam logic [W-1:0] D5   = {4'h5, {13{8'hA5}}};
  localparam logic [W-1:0] D9   = {27{4'hC}};

  logic          rclk = 1'b0;
  logic          reset_l;
  logic [W-1:0]  din;
  logic [AW-1:0] wr_adr;
  logic          wr_en;
  logic [3:0]    word_wen;
  logic [AW-1:0] rd_adr0, rd_adr1;
  logic          read_en0, read_en1;
  logic          rst_tri_en, sehold;
  logic [W-1:0]  dout0_a, dout1_a, dout0_b, dout1_b, dout0_c, dout1_c;

  always #5 rclk = ~rclk;

  bw_r_rf_2r1w_param #(.DEPTH(32), .WIDTH(W), .LANES(4), .BYPASS(1)) u_dut_a (
    .rclk(rclk), .reset_l(reset_l), .din(din), .wr_adr(wr_adr), .wr_en(wr_en),
    .word_wen(word_wen), .rd_adr0(rd_adr0), .read_en0(read_en0),
    .rd_adr1(rd_adr1), .read_en1(read_en1), .rst_tri_en(rst_tri_en),
    .sehold(sehold), .dout0(dout0_a), .dout1(dout1_a));

  bw_r_rf_2r1w_param #(.DEPTH(32), .WIDTH(W), .LANES(4), .BYPASS(0)) u_dut_b (
    .rclk(rclk), .reset_l(reset_l), .din(din), .wr_adr(wr_adr), .wr_en(wr_en),
    .word_wen(word_wen), .rd_adr0(rd_adr0), .read_en0(read_en0),
    .rd_adr1(rd_adr1), .read_en1(read_en1), .rst_tri_en(rst_tri_en),
    .sehold(sehold), .dout0(dout0_b), .dout1(dout1_b));

  bw_r_rf_2r1w_param #(.DEPTH(20), .WIDTH(W), .LANES(4), .BYPASS(1)) u_dut_c (
    .rclk(rclk), .reset_l(reset_l), .din(din), .wr_adr(wr_adr), .wr_en(wr_en),
    .word_wen(word_wen), .rd_adr0(rd_adr0), .read_en0(read_en0),
    .rd_adr1(rd_adr1), .read_en1(read_en1), .rst_tri_en(rst_tri_en),
    .sehold(sehold), .dout0(dout0_c), .dout1(dout1_c));

  typedef struct {
    int           due;
    int           dut;
    int           port;
    logic [W-1:0] val;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   e = 0;

  always @(posedge rclk) e <= e + 1;

  function automatic logic [W-1:0] get_act(input int d, input int p);
    case ({d[1:0], p[0]})
      3'b000:  return dout0_a;
      3'b001:  return dout1_a;
      3'b010:  return dout0_b;
      3'b011:  return dout1_b;
      3'b100:  return dout0_c;
      default: return dout1_c;
    endcase
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: compare every expectation whose due cycle has arrived.
  always @(negedge rclk) begin
    int i;
    i = 0;
    while (i < exp_q.size()) begin
      if (exp_q[i].due == e) begin
        chk($sformatf("%s dut%0d port%0d cyc%0d", exp_q[i].name, exp_q[i].dut,
                      exp_q[i].port, e),
            get_act(exp_q[i].dut, exp_q[i].port), exp_q[i].val);
        exp_q.delete(i);
      end else if (exp_q[i].due < e) begin
        checks++;
        errors++;
        $display("FAIL %s missed: due %0d now %0d", exp_q[i].name, exp_q[i].due, e);
        exp_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic push(input string name, input int d, input int p,
                      input logic [W-1:0] v, input int k);
    exp_t x;
    x.due = e + k; x.dut = d; x.port = p; x.val = v; x.name = name;
    exp_q.push_back(x);
  endtask

  task automatic push3(input string name, input int p, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic [W-1:0] vc, input int k);
    push(name, 0, p, va, k);
    push(name, 1, p, vb, k);
    push(name, 2, p, vc, k);
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; read_en0 = 1'b0; read_en1 = 1'b0;
    rst_tri_en = 1'b0; sehold = 1'b0; word_wen = 4'h0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [3:0] m);
    wr_adr = a; din = d; word_wen = m; wr_en = 1'b1;
  endtask

  task automatic rd0(input logic [AW-1:0] a);
    rd_adr0 = a; read_en0 = 1'b1;
  endtask

  task automatic rd1(input logic [AW-1:0] a);
    rd_adr1 = a; read_en1 = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] clr_adr [6];
    clr_adr = '{5'd3, 5'd4, 5'd5, 5'd7, 5'd9, 5'd12};

    reset_l = 1'b0; din = '0; wr_adr = '0; rd_adr0 = '0; rd_adr1 = '0;
    idle();
    repeat (3) step();
    push3("reset", 0, ZERO, ZERO, ZERO, 0);
    push3("reset", 1, ZERO, ZERO, ZERO, 0);
    reset_l = 1'b1;
    step();

    // Known background contents.
    for (int i = 0; i < 6; i++) begin
      wr(clr_adr[i], ZERO, 4'hF); step();
    end
    wr(5'd4, D4, 4'hF); step();
    wr(5'd9, D9, 4'hF); step();
    idle(); step();

    // T1: write then read next cycle on port 0; port 1 untouched.
    wr(5'd5, D5, 4'hF); step();
    idle(); rd0(5'd5);
    push3("t1_rd", 0, D5, D5, D5, 2);
    push3("t1_hold", 1, ZERO, ZERO, ZERO, 2);
    step(); idle(); step(); step();

    // T2: lane-2 only write, both ports read the same address.
    wr(5'd7, ONES, 4'b0100); step();
    idle(); rd0(5'd7); rd1(5'd7);
    push3("t2_lane2", 0, P2, P2, P2, 2);
    push3("t2_lane2", 1, P2, P2, P2, 2);
    step(); idle(); step(); step();

    // T3: same-cycle write/read of one address, then a plain read back.
    wr(5'd3, ONES, 4'b0011); rd0(5'd3); rd1(5'd3);
    push3("t3_same", 0, P3, ZERO, P3, 2);
    push3("t3_same", 1, P3, ZERO, P3, 2);
    step();
    idle(); rd0(5'd3); rd1(5'd3);
    push3("t3_after", 0, P3, P3, P3, 2);
    push3("t3_after", 1, P3, P3, P3, 2);
    step(); idle(); step(); step();

    // T4a: rst_tri_en live at the array-write edge blocks the write.
    wr(5'd9, ONES, 4'hF); step();
    idle(); rst_tri_en = 1'b1; step();
    rst_tri_en = 1'b0; rd0(5'd9);
    push3("t4_tri", 0, D9, D9, D9, 2);
    step(); idle(); step(); step();

    // T4b: sehold freezes a captured port-0 read while inputs change.
    rd0(5'd5);
    push3("t4_pre", 0, D5, D5, D5, 2);
    step();
    for (int j = 0; j < 3; j++) begin
      sehold = 1'b1;
      rd0(5'd9); rd1(5'd7);
      wr(5'd5, {27{4'(j + 1)}}, 4'hF);
      push3("t4_hold", 0, D5, D5, D5, 2);
      push3("t4_hold", 1, P3, P3, P3, 2);
      step();
    end
    idle();
    push3("t4_rel", 0, D5, D5, D5, 2);
    push3("t4_rel", 1, P3, P3, P3, 2);
    step();
    idle(); rd0(5'd5);
    push3("t4_mem5", 0, D5, D5, D5, 2);
    step(); idle(); step(); step();

    // T5: reset one cycle after a write loses that write, keeps the array.
    wr(5'd12, ONES, 4'hF); step();
    idle(); reset_l = 1'b0;
    push3("t5_rst", 0, ZERO, ZERO, ZERO, 1);
    push3("t5_rst", 1, ZERO, ZERO, ZERO, 1);
    step();
    reset_l = 1'b1; step();
    rd0(5'd12); rd1(5'd4);
    push3("t5_adr12", 0, ZERO, ZERO, ZERO, 2);
    push3("t5_adr4", 1, D4, D4, D4, 2);
    step(); idle(); step(); step();

    // T6: address 25 is out of range only for the 20-deep instance.
    wr(5'd25, ONES, 4'hF); step();
    idle(); rd0(5'd25); rd1(5'd5);
    push3("t6_oor", 0, ONES, ONES, ZERO, 2);
    push3("t6_adr5", 1, D5, D5, D5, 2);
    step(); idle(); step(); step();

    // Drain with a bounded wait.
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) step();
    while (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: due %0d now %0d", exp_q[0].name, exp_q[0].due, e);
      void'(exp_q.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
